// File: rtl/load_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for the load align unit.
package load_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] offset);
    return (((op == OP_LH) || (op == OP_LHU)) && offset[0]) ||
           ((op == OP_LW) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
module load_extend
  import load_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    case (offset)
      2'b00:   w_byte = word[7:0];
      2'b01:   w_byte = word[15:8];
      2'b10:   w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (op)
      OP_LB:   result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  result = {24'b0, w_byte};
      OP_LH:   result = {{16{w_half[15]}}, w_half};
      OP_LHU:  result = {16'b0, w_half};
      OP_LW:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: word read, timeout abort, lane extract, writeback handshake.
// Optional build macro MISALIGN_TRAP_EN turns misaligned LH/LHU/LW into an immediate error response.
module load_align_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err
);

  state_t r_state;
  state_t w_stateNext;

  logic [5:0]       r_op;
  logic [31:0]      r_addr;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_respData;
  logic             r_respErr;

  logic             w_accept;
  logic             w_trap;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cntNext;
  logic [31:0]      w_ext;

  assign w_accept = req_valid && (r_state == ST_IDLE) && is_load(req_op);

`ifdef MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(req_op, req_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // The counter holds the number of completed WAIT cycles; the abort fires on the TIMEOUT-th.
  assign w_cntNext = r_cnt + 1'b1;
  assign w_timeout = (w_cntNext == CNT_W'(TIMEOUT));

  load_extend u_extend (
    .op     (r_op),
    .offset (r_addr[1:0]),
    .word   (mem_rdata),
    .result (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_stateNext = w_trap ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_stateNext = ST_WAIT;
      ST_WAIT:  if (mem_rvalid || w_timeout) w_stateNext = ST_RESP;
      ST_RESP:  if (resp_ready) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    mem_rd_en  = (r_state == ST_ISSUE);
    resp_valid = (r_state == ST_RESP);
  end

  // Response data wins over a coincident timeout because it is tested first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_respData <= '0;
      r_respErr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= req_op;
        r_addr <= req_addr;
        r_rd   <= req_rd;
      end
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_accept && w_trap) begin
            r_respData <= '0;
            r_respErr  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_respData <= w_ext;
            r_respErr  <= 1'b0;
          end else if (w_timeout) begin
            r_respData <= '0;
            r_respErr  <= 1'b1;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_cnt     <= '0;
            r_respErr <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign resp_data = r_respData;
  assign resp_rd   = r_rd;
  assign resp_err  = r_respErr;

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized self-checking bench for load_align_unit against a transaction-level timing/data model.
module tb_load_align_unit;

  localparam int TO = 255;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  always #5 clk = ~clk;

  load_align_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Expected timeline of the one transaction in flight, in absolute cycle numbers.
  bit          mActive = 1'b0;
  bit          mRdEn = 1'b0;
  int          mAcc = 0;
  int          mResp = 0;
  int          mDone = 0;
  logic [31:0] mAddr = '0;
  logic [31:0] mData = '0;
  logic        mErr = 1'b0;
  logic [4:0]  mRd = '0;
  int          memAt = -1;
  logic [31:0] memWord = '0;

  bit cBusy, cRv, cRd;

  logic [5:0] loadOps [5] = '{LB, LH, LW, LBU, LHU};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit isLoad(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic bit isTrap(input logic [5:0] op, input logic [31:0] addr);
    return TRAP_BUILD && ((((op == LH) || (op == LHU)) && addr[0]) ||
                          ((op == LW) && (addr[1:0] != 2'b00)));
  endfunction

  function automatic logic [31:0] modelValue(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
    h = (w >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
    case (op)
      LB:      return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      LBU:     return b;
      LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      LHU:     return h;
      default: return w;
    endcase
  endfunction

  // Every cycle after the edge settles, hold the DUT against the expected timeline.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      cBusy = mActive && (cyc > mAcc) && (cyc <= mDone);
      cRv   = mActive && (cyc >= mResp) && (cyc <= mDone);
      cRd   = mActive && mRdEn && (cyc == mAcc + 1);
      checkOutput("req_ready", 32'(req_ready), 32'(!cBusy));
      checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(cRd));
      if (cRd) checkOutput("mem_addr", mem_addr, {mAddr[31:2], 2'b00});
      checkOutput("resp_valid", 32'(resp_valid), 32'(cRv));
      if (cRv) begin
        checkOutput("resp_data", resp_data, mData);
        checkOutput("resp_rd", 32'(resp_rd), 32'(mRd));
        checkOutput("resp_err", 32'(resp_err), 32'(mErr));
      end else begin
        checkOutput("resp_err_idle", 32'(resp_err), 32'h0);
      end
    end
  end

  // Memory: the scheduled response, plus rvalid noise wherever the unit must ignore it.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc == memAt) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memWord;
      end else begin
        mem_rdata = $urandom;
        if (mActive && (cyc >= mAcc + 1) && (cyc < mResp)) mem_rvalid = 1'b0;
        else mem_rvalid = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic idleCycles(input int n, input bit noise);
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op = 6'($urandom);
      if (isLoad(op)) op = op ^ 6'b001000;
      req_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      req_op     = op;
      req_addr   = $urandom;
      req_rd     = 5'($urandom);
      resp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // One load from acceptance to handshake; lat is cycles from mem_rd_en to rvalid.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd,
                               input int lat, input logic [31:0] word, input int stall,
                               input bit pin, input logic [31:0] pinData, input logic pinErr,
                               input int pinLat);
    int firstRv;
    @(negedge clk);
    mAcc  = cyc;
    mAddr = addr;
    mRd   = rd;
    if (isTrap(op, addr)) begin
      mRdEn = 1'b0;
      mResp = mAcc + 1;
      mData = '0;
      mErr  = 1'b1;
      memAt = -1;
    end else begin
      mRdEn   = 1'b1;
      memAt   = mAcc + 1 + lat;
      memWord = word;
      if (lat <= TO) begin
        mResp = mAcc + 2 + lat;
        mData = modelValue(op, addr, word);
        mErr  = 1'b0;
      end else begin
        mResp = mAcc + 2 + TO;
        mData = '0;
        mErr  = 1'b1;
      end
    end
    mDone   = mResp + stall;
    mActive = 1'b1;
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_rd     = rd;
    resp_ready = 1'($urandom_range(0, 1));
    firstRv = -1;
    for (int m = mAcc + 1; m <= mDone; m++) begin
      @(negedge clk);
      if (resp_valid && firstRv < 0) firstRv = cyc;
      req_valid = 1'($urandom_range(0, 1));
      req_op    = loadOps[$urandom_range(0, 4)];
      req_addr  = $urandom;
      req_rd    = 5'($urandom);
      if (cyc >= mDone) resp_ready = 1'b1;
      else if (cyc < mResp) resp_ready = 1'($urandom_range(0, 1));
      else resp_ready = 1'b0;
      if (pin && cyc == mResp) begin
        checkOutput("pin_data", resp_data, pinData);
        checkOutput("pin_err", 32'(resp_err), 32'(pinErr));
      end
    end
    if (pin && pinLat > 0) checkOutput("pin_latency", 32'(firstRv - mAcc), 32'(pinLat));
  endtask

  initial begin
    logic [5:0] op;
    int lat, sel, stall;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_data", resp_data, 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2, 1'b0);

    // Lane and extension literals.
    applyStimulus(LB,  32'h0000_1003, 5'd7,  2, 32'h80FF_1234, 0, 1'b1, 32'hFFFF_FF80, 1'b0, 4);
    applyStimulus(LBU, 32'h0000_1003, 5'd8,  1, 32'h80FF_1234, 1, 1'b1, 32'h0000_0080, 1'b0, 3);
    applyStimulus(LHU, 32'h0000_2002, 5'd9,  2, 32'hBEEF_0001, 0, 1'b1, 32'h0000_BEEF, 1'b0, 4);
    applyStimulus(LH,  32'h0000_2002, 5'd10, 1, 32'hBEEF_0001, 0, 1'b1, 32'hFFFF_BEEF, 1'b0, 3);
    applyStimulus(LW,  32'h0000_0100, 5'd11, 3, 32'h1234_5678, 0, 1'b1, 32'h1234_5678, 1'b0, 5);

    // Writeback stall, then a store opcode in IDLE that must not start a read.
    applyStimulus(LW, 32'h0000_0204, 5'd12, 2, 32'hCAFE_F00D, 4, 1'b1, 32'hCAFE_F00D, 1'b0, 4);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 6'b101011;
    req_addr  = 32'h0000_0300;
    idleCycles(3, 1'b0);

    // Timeout with a late response that lands after the return to IDLE, then the data/timeout tie.
    applyStimulus(LW, 32'h0000_0400, 5'd13, TO + 6, 32'h5555_AAAA, 0, 1'b1, 32'h0, 1'b1, TO + 2);
    idleCycles(10, 1'b0);
    applyStimulus(LBU, 32'h0000_0401, 5'd14, TO, 32'h0000_7F00, 0, 1'b1, 32'h0000_007F, 1'b0, TO + 2);

    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    applyStimulus(LW, 32'h0000_0501, 5'd15, 2, 32'h0BAD_0BAD, 0, 1'b1, 32'h0, 1'b1, 1);
`else
    applyStimulus(LW, 32'h0000_0501, 5'd15, 2, 32'h0BAD_0BAD, 0, 1'b1, 32'h0BAD_0BAD, 1'b0, 4);
`endif

    // Reset while waiting for memory aborts the load; a later rvalid is ignored.
    @(negedge clk);
    mAcc = cyc; mAddr = 32'h0000_0600; mRd = 5'd3; mRdEn = 1'b1;
    mResp = mAcc + 2 + TO; mDone = mResp; mData = '0; mErr = 1'b1; memAt = -1; mActive = 1'b1;
    req_valid = 1'b1; req_op = LW; req_addr = 32'h0000_0600; req_rd = 5'd3; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    mActive = 1'b0;
    #1;
    checkOutput("midrst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("midrst_mem_addr", mem_addr, 32'h0);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("midrst_resp_rd", 32'(resp_rd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    memAt = cyc + 2;
    memWord = 32'hDEAD_BEEF;
    idleCycles(8, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op  = loadOps[$urandom_range(0, 4)];
      sel = $urandom_range(0, 99);
      if (sel < 75) lat = $urandom_range(1, 5);
      else if (sel < 92) lat = $urandom_range(6, 20);
      else if (sel < 96) lat = TO;
      else lat = TO + 1;
      stall = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      applyStimulus(op, $urandom, 5'($urandom), lat, $urandom, stall, 1'b0, 32'h0, 1'b0, 0);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3), 1'b1);
    end
    idleCycles(3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
